pipe_hazard_chain: RTL
======================

// Module: pipe_hazard_chain
// PURPOSE
//  Parametrised post-decode pipeline tracker: replaces fixed per-stage buffer modules with one STAGES-deep chain
//  carrying valid/rd/we/ctrl/result per instruction. Sits between ID and the register file write port.
//  Detects RAW hazards, selects forwarding data for both ID source operands, stalls ID on unready producers
//  (load-use), and accepts flush and external stall. Emits the write-back request from the last stage.
// PARAMETERS
//  STAGES  3   post-ID stages: 0 = ID/EX, STAGES-1 = MEM/WB (min 2)
//  DATA_W  32  result/forward data width
//  REG_AW  5   register address width; address 0 is hard-wired zero
//  CTRL_W  8   opaque per-stage control payload width
// PORTS
//  clk_i            in   1               clock
//  rst_i            in   1               synchronous, active-high reset
//  id_valid_i       in   1               ID holds a real instruction
//  id_rs1_i/id_rs2_i in  REG_AW          ID source registers
//  id_rs1_used_i/id_rs2_used_i in 1      source is actually read
//  id_rd_i          in   REG_AW          ID destination
//  id_we_i          in   1               ID instruction writes rd
//  id_ctrl_i        in   CTRL_W          control payload for downstream stages
//  flush_i          in   1               kill the ID instruction (branch taken)
//  ext_stall_i      in   1               freeze entire chain (memory wait)
//  st_res_valid_i   in   STAGES          stage k datapath has produced its entry's result this cycle
//  st_result_i      in   STAGES*DATA_W   stage k result, slice k
//  stall_id_o       out  1               hold PC and IF/ID register
//  fwd_rs1_hit_o/fwd_rs2_hit_o out 1     use forwarded data instead of register file
//  fwd_rs1_o/fwd_rs2_o out DATA_W        forwarded operand data
//  st_valid_o       out  STAGES          per-stage valid
//  st_rd_o          out  STAGES*REG_AW   per-stage rd
//  st_ctrl_o        out  STAGES*CTRL_W   per-stage control payload
//  wb_we_o          out  1               register-file write enable
//  wb_rd_o          out  REG_AW          write address
//  wb_data_o        out  DATA_W          write data
//  stall_cnt_o      out  32              hazard stall cycles, saturating at 0xFFFF_FFFF
// BEHAVIOUR
//  - Entry = {valid, we, rd, ctrl, rdy, data}. Reset: all fields 0, stall_cnt_o 0; all outputs 0.
//  - Match(k, rs): valid[k] & we[k] & rd[k]==rs & rs!=0 & rs_used. Youngest (lowest k) match wins.
//  - Forward from winner: rdy[k] -> stored data; else st_res_valid_i[k] -> st_result_i[k] (same cycle,
//    combinational); else hazard. No match -> hit=0, data=0.
//  - hazard = unresolved winner on rs1 or rs2. stall_id_o = hazard | ext_stall_i.
//  - Issue iff id_valid_i & !stall_id_o & !flush_i; otherwise a bubble (valid=0) enters stage 0.
//  - ext_stall_i=0: stage k+1 <= stage k; data/rdy take st_result_i[k]/1 on st_res_valid_i[k], else carried.
//  - ext_stall_i=1: no movement, no issue; stage k captures st_result_i[k] in place (rdy<=1) on st_res_valid_i[k].
//  - flush_i with ext_stall_i: stall wins; flush source holds flush_i until stall_id_o drops.
//  - wb_*: combinational from stage STAGES-1: wb_we_o = valid&we&rdy&rd!=0. One write per entry.
//    Entry held in last stage by ext_stall_i is not re-written (write gated on advance or first cycle only).
//  - Latency: issued entry reaches stage k after k+1 unstalled cycles; write-back STAGES cycles after issue.
//  - stall_cnt_o +1 per cycle with hazard=1 (ext stall excluded); holds at all-ones.
//  - rst_i mid-operation: all in-flight entries dropped next cycle, no write-back issued.
// STRUCTURE
//  - pipe_pkg: entry field widths, REG_ZERO constant, STAGES lower bound check.
//  - Sub-module pipe_fwd_match: per-operand priority search + ready/hazard decision; instantiated for rs1 and rs2.
//  - Top: entry register array, advance/capture logic, issue gating, write-back gating, stall counter.
// TESTING
//  1. Issue x5 writer, st_res_valid_i[0]=1 result 0x11; next ID reads x5 -> hit=1, fwd=0x11, stall_id_o=0.
//  2. Load x6 (st_res_valid_i[0]=0), next ID reads x6 -> stall_id_o=1 one cycle, stall_cnt_o=1;
//     then st_result_i[1]=0xDEAD -> fwd=0xDEAD, issue proceeds; wb_data_o=0xDEAD 2 cycles later.
//  3. x7 writers in stage 0 (0x2) and stage 2 (0x1); ID reads x7 -> fwd=0x2.
//  4. Writer with rd=0, ID reads x0 -> hit=0, no stall; wb_we_o stays 0 as entry exits.
//  5. ext_stall_i 3 cycles, st_res_valid_i[1]=1 (0x55) in cycle 1 -> chain frozen, data captured;
//     after release exactly one wb_we_o pulse with 0x55.
//  6. flush_i with id_valid_i=1 -> stage 0 bubble; assert rst_i with 3 valid entries -> st_valid_o=0,
//     stall_cnt_o=0 next cycle, no wb_we_o.

Source files
------------

// File: rtl/pipe_hazard_chain_pkg.sv
// pipe_hazard_chain_pkg: shared constants and types for the post-decode hazard chain.
// Default field widths, the hard-wired zero register, forward-source encoding, depth check.
package pipe_hazard_chain_pkg;

  localparam int MIN_STAGES = 2;
  localparam int DEF_STAGES = 3;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_CTRL_W = 8;
  localparam int REG_ZERO   = 0;
  localparam int CNT_W      = 32;

  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_STORED,
    FWD_LIVE,
    FWD_HAZ
  } fwd_src_e;

  function automatic bit stages_ok(input int n);
    return n >= MIN_STAGES;
  endfunction

endpackage

// File: rtl/pipe_fwd_match.sv
// pipe_fwd_match: youngest-first producer search for one ID source operand.
// In: per-stage valid/we/rd/rdy/data, live results, rs + rs_used. Out: hit, data, hazard.
module pipe_fwd_match
  import pipe_hazard_chain_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [STAGES-1:0]             st_valid,
  input  logic [STAGES-1:0]             st_we,
  input  logic [STAGES-1:0][REG_AW-1:0] st_rd,
  input  logic [STAGES-1:0]             st_rdy,
  input  logic [STAGES-1:0][DATA_W-1:0] st_data,
  input  logic [STAGES-1:0]             res_valid,
  input  logic [STAGES-1:0][DATA_W-1:0] result,
  input  logic [REG_AW-1:0]             rs,
  input  logic                          rs_used,
  output logic                          hit,
  output logic [DATA_W-1:0]             data,
  output logic                          hazard
);

  logic              found;
  logic              s_rdy;
  logic              s_live;
  logic [DATA_W-1:0] s_data;
  logic [DATA_W-1:0] s_res;
  logic              rs_live;
  fwd_src_e          src;

  assign rs_live = rs_used && (rs != REG_AW'(REG_ZERO));

  // Walk oldest to youngest so the lowest matching stage overrides.
  always_comb begin
    found  = 1'b0;
    s_rdy  = 1'b0;
    s_live = 1'b0;
    s_data = '0;
    s_res  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (rs_live && st_valid[k] && st_we[k] &&
          st_rd[k] == rs) begin
        found  = 1'b1;
        s_rdy  = st_rdy[k];
        s_live = res_valid[k];
        s_data = st_data[k];
        s_res  = result[k];
      end
    end
  end

  always_comb begin
    src = FWD_NONE;
    unique case (1'b1)
      !found:                    src = FWD_NONE;
      found && s_rdy:            src = FWD_STORED;
      found && !s_rdy && s_live: src = FWD_LIVE;
      found && !s_rdy && !s_live: src = FWD_HAZ;
      default:                   src = FWD_NONE;
    endcase
  end

  always_comb begin
    hit    = 1'b0;
    data   = '0;
    hazard = 1'b0;
    unique case (src)
      FWD_STORED: begin
        hit  = 1'b1;
        data = s_data;
      end
      FWD_LIVE: begin
        hit  = 1'b1;
        data = s_res;
      end
      FWD_HAZ:  hazard = 1'b1;
      default:  hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_chain.sv
// pipe_hazard_chain: STAGES-deep post-ID entry chain with RAW forwarding,
// load-use stall, flush/external stall, last-stage write-back and stall counter.
// In:  clk_i, rst_i, id_* (ID instruction), flush_i, ext_stall_i, st_res_valid_i, st_result_i.
// Out: stall_id_o, fwd_rs*_hit_o, fwd_rs*_o, st_valid_o, st_rd_o, st_ctrl_o, wb_*, stall_cnt_o.
module pipe_hazard_chain
  import pipe_hazard_chain_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       id_valid_i,
  input  logic [REG_AW-1:0]          id_rs1_i,
  input  logic [REG_AW-1:0]          id_rs2_i,
  input  logic                       id_rs1_used_i,
  input  logic                       id_rs2_used_i,
  input  logic [REG_AW-1:0]          id_rd_i,
  input  logic                       id_we_i,
  input  logic [CTRL_W-1:0]          id_ctrl_i,
  input  logic                       flush_i,
  input  logic                       ext_stall_i,
  input  logic [STAGES-1:0]          st_res_valid_i,
  input  logic [STAGES*DATA_W-1:0]   st_result_i,
  output logic                       stall_id_o,
  output logic                       fwd_rs1_hit_o,
  output logic                       fwd_rs2_hit_o,
  output logic [DATA_W-1:0]          fwd_rs1_o,
  output logic [DATA_W-1:0]          fwd_rs2_o,
  output logic [STAGES-1:0]          st_valid_o,
  output logic [STAGES*REG_AW-1:0]   st_rd_o,
  output logic [STAGES*CTRL_W-1:0]   st_ctrl_o,
  output logic                       wb_we_o,
  output logic [REG_AW-1:0]          wb_rd_o,
  output logic [DATA_W-1:0]          wb_data_o,
  output logic [CNT_W-1:0]           stall_cnt_o
);

  localparam int L = STAGES - 1;

  if (!stages_ok(STAGES)) begin : g_bad_depth
    $error("pipe_hazard_chain: STAGES below minimum");
  end

  logic [STAGES-1:0]             v_q;
  logic [STAGES-1:0]             we_q;
  logic [STAGES-1:0]             rdy_q;
  logic [STAGES-1:0][REG_AW-1:0] rd_q;
  logic [STAGES-1:0][CTRL_W-1:0] ctrl_q;
  logic [STAGES-1:0][DATA_W-1:0] data_q;
  logic [STAGES-1:0][DATA_W-1:0] res;
  logic                          wb_done_q;
  logic [CNT_W-1:0]              cnt_q;
  logic                          hz1;
  logic                          hz2;
  logic                          hazard;
  logic                          issue;

  assign res = st_result_i;

  pipe_fwd_match #(
    .STAGES (STAGES),
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rs1 (
    .st_valid  (v_q),
    .st_we     (we_q),
    .st_rd     (rd_q),
    .st_rdy    (rdy_q),
    .st_data   (data_q),
    .res_valid (st_res_valid_i),
    .result    (res),
    .rs        (id_rs1_i),
    .rs_used   (id_rs1_used_i),
    .hit       (fwd_rs1_hit_o),
    .data      (fwd_rs1_o),
    .hazard    (hz1)
  );

  pipe_fwd_match #(
    .STAGES (STAGES),
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rs2 (
    .st_valid  (v_q),
    .st_we     (we_q),
    .st_rd     (rd_q),
    .st_rdy    (rdy_q),
    .st_data   (data_q),
    .res_valid (st_res_valid_i),
    .result    (res),
    .rs        (id_rs2_i),
    .rs_used   (id_rs2_used_i),
    .hit       (fwd_rs2_hit_o),
    .data      (fwd_rs2_o),
    .hazard    (hz2)
  );

  assign hazard     = hz1 | hz2;
  assign stall_id_o = hazard | ext_stall_i;
  assign issue      = id_valid_i & ~stall_id_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q       <= '0;
      we_q      <= '0;
      rdy_q     <= '0;
      rd_q      <= '0;
      ctrl_q    <= '0;
      data_q    <= '0;
      wb_done_q <= 1'b0;
    end else if (ext_stall_i) begin
      // Frozen: each stage may still finish its own result in place.
      for (int k = 0; k < STAGES; k++) begin
        if (st_res_valid_i[k]) begin
          data_q[k] <= res[k];
          rdy_q[k]  <= 1'b1;
        end
      end
      // Remember a write already made by the held last-stage entry.
      wb_done_q <= wb_done_q | wb_we_o;
    end else begin
      v_q[0]    <= issue;
      we_q[0]   <= issue & id_we_i;
      rd_q[0]   <= issue ? id_rd_i : '0;
      ctrl_q[0] <= issue ? id_ctrl_i : '0;
      rdy_q[0]  <= 1'b0;
      data_q[0] <= '0;
      for (int k = 0; k < L; k++) begin
        v_q[k+1]    <= v_q[k];
        we_q[k+1]   <= we_q[k];
        rd_q[k+1]   <= rd_q[k];
        ctrl_q[k+1] <= ctrl_q[k];
        rdy_q[k+1]  <= rdy_q[k] | st_res_valid_i[k];
        data_q[k+1] <= st_res_valid_i[k] ? res[k] : data_q[k];
      end
      wb_done_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (hazard && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Reset suppresses the write of whatever is leaving the chain.
  assign wb_we_o = v_q[L] & we_q[L] & rdy_q[L] &
                   (rd_q[L] != REG_AW'(REG_ZERO)) &
                   ~wb_done_q & ~rst_i;
  assign wb_rd_o     = rd_q[L];
  assign wb_data_o   = data_q[L];
  assign st_valid_o  = v_q;
  assign st_rd_o     = rd_q;
  assign st_ctrl_o   = ctrl_q;
  assign stall_cnt_o = cnt_q;

endmodule
